// File: rtl/record_serializer.sv
// Purpose : buffers whole records (RECORD_WORDS words) and shifts them out one word at a time, word 0 first.
// Latency : a record written at edge N is presented on data_out (show-ahead) from cycle N+1.
// Backpressure: full refuses whole-record writes until a full record slot is free; empty makes reads no-ops.
// Optional: define RECORD_SERIALIZER_ERR_EN to add sticky overflow/underflow outputs.
module record_serializer #(
   parameter int WORD_SIZE    = 8,
   parameter int RECORD_WORDS = 16,
   parameter int SLOTS        = 8,
   localparam int RECORD_SIZE_BITS = WORD_SIZE * RECORD_WORDS,
   localparam int STORAGE_SIZE     = SLOTS * RECORD_WORDS,
   localparam int STORAGE_POS_SIZE = $clog2(STORAGE_SIZE)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        write_en,
   input  logic [RECORD_SIZE_BITS-1:0] data_in,
   input  logic                        read_en,
   output logic [WORD_SIZE-1:0]        data_out,
   output logic                        last,
   output logic [STORAGE_POS_SIZE:0]   size,
   output logic                        full,
   output logic                        empty
`ifdef RECORD_SERIALIZER_ERR_EN
   ,
   output logic                        overflow,
   output logic                        underflow
`endif
);

   // Pointers carry one extra bit so that size can span 0..STORAGE_SIZE.
   localparam int PW = STORAGE_POS_SIZE + 1;

   logic [WORD_SIZE-1:0]        mem_q [STORAGE_SIZE];
   logic [WORD_SIZE-1:0]        mem_d [STORAGE_SIZE];
   logic [PW-1:0]               write_pos_q, write_pos_d;
   logic [PW-1:0]               read_pos_q, read_pos_d;
   logic [STORAGE_POS_SIZE-1:0] rd_idx;
   logic [STORAGE_POS_SIZE-1:0] wr_idx;
   logic                        do_write, do_read;

   // Status is derived purely from the pre-edge pointers.
   assign size     = write_pos_q - read_pos_q;
   assign empty    = (size == '0);
   assign full     = (PW'(STORAGE_SIZE) - size) < PW'(RECORD_WORDS);
   assign rd_idx   = read_pos_q[STORAGE_POS_SIZE-1:0];
   assign wr_idx   = write_pos_q[STORAGE_POS_SIZE-1:0];
   assign data_out = empty ? '0 : mem_q[rd_idx];
   // Low pointer bits give the word offset inside the current record.
   assign last     = !empty && ((read_pos_q & PW'(RECORD_WORDS - 1)) == PW'(RECORD_WORDS - 1));

   assign do_write = write_en && !full;
   assign do_read  = read_en && !empty;

   // Next pointer values: writes advance by a whole record, reads by one word.
   always_comb begin
      write_pos_d = write_pos_q;
      read_pos_d  = read_pos_q;
      if (do_write) begin
         write_pos_d = write_pos_q + PW'(RECORD_WORDS);
      end
      if (do_read) begin
         read_pos_d = read_pos_q + PW'(1);
      end
   end

   // Next storage contents: the whole record lands in one slot; write_pos is record aligned so no wrap inside it.
   always_comb begin
      mem_d = mem_q;
      if (do_write) begin
         for (int k = 0; k < RECORD_WORDS; k++) begin
            mem_d[wr_idx + STORAGE_POS_SIZE'(k)] = data_in[k*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   // Pointer registers; reset wins over any concurrent access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_pos_q <= '0;
         read_pos_q  <= '0;
      end else begin
         write_pos_q <= write_pos_d;
         read_pos_q  <= read_pos_d;
      end
   end

   // Storage array; contents are meaningless after reset because the pointers are cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef RECORD_SERIALIZER_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error flags: any refused request latches its flag until reset.
   always_comb begin
      overflow_d  = overflow_q | (write_en & full);
      underflow_d = underflow_q | (read_en & empty);
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_record_serializer.sv
// Self-checking bench for record_serializer (WORD_SIZE=8, RECORD_WORDS=4, SLOTS=2).
// Reference model: a queue of {last, byte} entries, one per buffered word.
// Directed scenarios followed by randomized traffic with occasional resets.
module tb_record_serializer;

   localparam int W  = 8;
   localparam int RW = 4;
   localparam int SL = 2;
   localparam int CAP = RW * SL;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          write_en;
   logic [31:0]   data_in;
   logic          read_en;
   logic [7:0]    data_out;
   logic          last;
   logic [3:0]    size;
   logic          full;
   logic          empty;
`ifdef RECORD_SERIALIZER_ERR_EN
   logic          overflow;
   logic          underflow;
`endif

   always #5 clk = ~clk;

   record_serializer #(
      .WORD_SIZE    (W),
      .RECORD_WORDS (RW),
      .SLOTS        (SL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .write_en (write_en),
      .data_in  (data_in),
      .read_en  (read_en),
      .data_out (data_out),
      .last     (last),
      .size     (size),
      .full     (full),
      .empty    (empty)
`ifdef RECORD_SERIALIZER_ERR_EN
      ,
      .overflow (overflow),
      .underflow(underflow)
`endif
   );

   int         vectors = 0;
   int         miscompares = 0;
   logic [8:0] mq[$];
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit m_empty;
      m_empty = (mq.size() == 0);
      chk("size",  64'(size),  64'(mq.size()));
      chk("empty", 64'(empty), 64'(m_empty));
      chk("full",  64'(full),  64'((CAP - mq.size()) < RW));
      chk("data_out", 64'(data_out), m_empty ? 64'(0) : 64'(mq[0][7:0]));
      chk("last",  64'(last),  m_empty ? 64'(0) : 64'(mq[0][8]));
`ifdef RECORD_SERIALIZER_ERR_EN
      chk("overflow",  64'(overflow),  64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
`endif
   endtask

   // One clock: drive inputs, advance model with pre-edge status, compare after the edge.
   task automatic step(input bit rst, input bit we, input logic [31:0] din, input bit re);
      bit m_full, m_empty;
      rst_n    = !rst;
      write_en = we;
      data_in  = din;
      read_en  = re;
      m_empty  = (mq.size() == 0);
      m_full   = (CAP - mq.size()) < RW;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (we && m_full)  m_ovf = 1'b1;
         if (re && m_empty) m_unf = 1'b1;
         if (re && !m_empty) void'(mq.pop_front());
         if (we && !m_full) begin
            for (int k = 0; k < RW; k++) mq.push_back({k == RW - 1, din[k*8 +: 8]});
         end
      end
      #1;
      check_outputs();
   endtask

   logic [7:0] s1_bytes [4];

   initial begin
      rst_n = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;

      // Reset state
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_size", 64'(size), 64'(0));
      chk("rst_empty", 64'(empty), 64'(1));

      // 1. Single record, read out in order
      s1_bytes[0] = 8'h11; s1_bytes[1] = 8'h22; s1_bytes[2] = 8'h33; s1_bytes[3] = 8'h44;
      step(0, 1, 32'h44332211, 0);
      chk("s1_size4", 64'(size), 64'(4));
      for (int i = 0; i < 4; i++) begin
         chk("s1_word", 64'(data_out), 64'(s1_bytes[i]));
         chk("s1_last", 64'(last), 64'(i == 3));
         step(0, 0, 0, 1);
      end
      chk("s1_empty_dout", 64'(data_out), 64'(0));

      // 2. Fill, refused write, partial drain keeps full
      step(0, 1, 32'hA3A2A1A0, 0);
      step(0, 1, 32'hB3B2B1B0, 0);
      chk("s2_full", 64'(full), 64'(1));
      step(0, 1, 32'hC3C2C1C0, 0);
      chk("s2_size8", 64'(size), 64'(8));
      step(0, 0, 0, 1);
      chk("s2_size7_full", 64'({size, full}), 64'({4'd7, 1'b1}));
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
      chk("s2_notfull", 64'(full), 64'(0));

      // 3. Simultaneous write and read at size 4
      step(0, 1, 32'hD3D2D1D0, 1);
      chk("s3_size7", 64'(size), 64'(7));
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1);

      // 4. Wrap-around rounds
      for (int n = 0; n < 5; n++) begin
         step(0, 1, 32'h03020100 + 32'h04040404 * n, 0);
         for (int i = 0; i < 4; i++) begin
            chk("s4_word", 64'(data_out), 64'(4 * n + i));
            step(0, 0, 0, 1);
         end
      end

      // 5. Reset mid-operation with a concurrent write
      step(0, 1, 32'h13121110, 0);
      step(0, 1, 32'h23222120, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 1, 32'h33323130, 1);
      chk("s5_rst", 64'({size, empty, full, last, data_out}), 64'({4'd0, 1'b1, 1'b0, 1'b0, 8'h00}));
      step(0, 1, 32'h43424140, 0);
      chk("s5_restart", 64'(data_out), 64'(8'h40));
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

      // 6. Refused accesses (sticky flags in the error build)
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 1, 32'h01010101, 0);
      step(0, 1, 32'h02020202, 0);
      step(0, 1, 32'h03030303, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35, $urandom, $urandom_range(0, 99) < 65);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
